count_ring_n: RTL and testbench

COUNT_RING_N -- requirements
Module: count_ring_n

---
 rtl/count_ring_n.sv | 75 +++++++
 tb/tb_count_ring_n.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/count_ring_n.sv
// One-hot ring counter with direction control, indexed load and a binary index output.
// WRAP and LDERR are registered single-cycle pulses that accompany the ring state.
module count_ring_n #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         EN,
    input  logic         DIR,
    input  logic         LOAD,
    input  logic [W-1:0] LD_IDX,
    output logic [N-1:0] Q,
    output logic [W-1:0] C,
    output logic         WRAP,
    output logic         LDERR
);

    localparam logic [N-1:0] RING_HOME = N'(1);
    localparam logic [W:0]   N_EXT     = (W+1)'(N);

    logic [N-1:0] ld_hot;
    logic [N-1:0] rot_up;
    logic [N-1:0] rot_dn;
    logic         ld_ok;

    // Load target and both rotations are formed ahead of the state register.
    always_comb begin
        ld_hot = '0;
        for (int i = 0; i < N; i++) begin
            ld_hot[i] = (LD_IDX == W'(i));
        end
        ld_ok  = ({1'b0, LD_IDX} < N_EXT);
        rot_up = {Q[N-2:0], Q[N-1]};
        rot_dn = {Q[0], Q[N-1:1]};
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            Q     <= RING_HOME;
            WRAP  <= 1'b0;
            LDERR <= 1'b0;
        end else begin
            WRAP  <= 1'b0;
            LDERR <= 1'b0;
            if (LOAD) begin
                // An out-of-range index leaves the ring untouched and suppresses stepping.
                if (ld_ok) begin
                    Q <= ld_hot;
                end else begin
                    LDERR <= 1'b1;
                end
            end else if (EN) begin
                if (DIR) begin
                    Q    <= rot_dn;
                    WRAP <= Q[0];
                end else begin
                    Q    <= rot_up;
                    WRAP <= Q[N-1];
                end
            end
        end
    end

    // Encoder is an OR of indices so it stays free of priority logic.
    always_comb begin
        C = '0;
        for (int i = 0; i < N; i++) begin
            if (Q[i]) begin
                C = C | W'(i);
            end
        end
    end

endmodule

// File: tb/tb_count_ring_n.sv
// Directed bench for count_ring_n: a 16-stage ring and a 10-stage ring driven in sequence.
module tb_count_ring_n;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        a_rst_n, a_en, a_dir, a_load;
    logic [3:0]  a_ld_idx;
    logic [15:0] a_q;
    logic [3:0]  a_c;
    logic        a_wrap, a_lderr;

    logic        b_rst_n, b_en, b_dir, b_load;
    logic [3:0]  b_ld_idx;
    logic [9:0]  b_q;
    logic [3:0]  b_c;
    logic        b_wrap, b_lderr;

    int checks   = 0;
    int failures = 0;
    bit a_live   = 1'b0;
    bit b_live   = 1'b0;

    count_ring_n #(.N(16)) dut_a (
        .CLK(CLK), .RST_N(a_rst_n), .EN(a_en), .DIR(a_dir), .LOAD(a_load),
        .LD_IDX(a_ld_idx), .Q(a_q), .C(a_c), .WRAP(a_wrap), .LDERR(a_lderr)
    );

    count_ring_n #(.N(10)) dut_b (
        .CLK(CLK), .RST_N(b_rst_n), .EN(b_en), .DIR(b_dir), .LOAD(b_load),
        .LD_IDX(b_ld_idx), .Q(b_q), .C(b_c), .WRAP(b_wrap), .LDERR(b_lderr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_a(input string tag, input int exp_c, input bit exp_wrap, input bit exp_lderr);
        logic [15:0] hot;
        hot = 16'd1 << exp_c;
        chk({tag, ".C"}, 32'(a_c), 32'(exp_c));
        chk({tag, ".Q"}, 32'(a_q), 32'(hot));
        chk({tag, ".WRAP"}, 32'(a_wrap), 32'(exp_wrap));
        chk({tag, ".LDERR"}, 32'(a_lderr), 32'(exp_lderr));
    endtask

    task automatic chk_b(input string tag, input int exp_c, input bit exp_wrap, input bit exp_lderr);
        logic [9:0] hot;
        hot = 10'd1 << exp_c;
        chk({tag, ".C"}, 32'(b_c), 32'(exp_c));
        chk({tag, ".Q"}, 32'(b_q), 32'(hot));
        chk({tag, ".WRAP"}, 32'(b_wrap), 32'(exp_wrap));
        chk({tag, ".LDERR"}, 32'(b_lderr), 32'(exp_lderr));
    endtask

    // Ring invariant on every cycle once each instance has seen reset.
    always @(negedge CLK) begin
        int idx;
        if (a_live) begin
            idx = 0;
            for (int i = 0; i < 16; i++) if (a_q[i]) idx = i;
            chk("a.onehot", 32'($countones(a_q)), 32'd1);
            chk("a.encode", 32'(a_c), 32'(idx));
        end
        if (b_live) begin
            idx = 0;
            for (int i = 0; i < 10; i++) if (b_q[i]) idx = i;
            chk("b.onehot", 32'($countones(b_q)), 32'd1);
            chk("b.encode", 32'(b_c), 32'(idx));
        end
    end

    initial begin
        a_rst_n = 1'b0; a_en = 1'b0; a_dir = 1'b0; a_load = 1'b0; a_ld_idx = 4'd0;
        b_rst_n = 1'b0; b_en = 1'b0; b_dir = 1'b0; b_load = 1'b0; b_ld_idx = 4'd0;

        // Reset overrides a concurrent load and enable.
        a_load = 1'b1; a_ld_idx = 4'd6; a_en = 1'b1;
        step();
        chk_a("a.reset", 0, 1'b0, 1'b0);
        a_live = 1'b1;

        // 17 up steps: 1..15, 0, 1 with WRAP after reaching 0.
        a_rst_n = 1'b1; a_load = 1'b0; a_en = 1'b1; a_dir = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step();
            chk_a("a.up", k % 16, (k == 16), 1'b0);
        end

        // Load 3, then 5 down steps: 2,1,0,15,14 with WRAP after 0->15.
        a_load = 1'b1; a_ld_idx = 4'd3; a_en = 1'b0;
        step();
        chk_a("a.load3", 3, 1'b0, 1'b0);
        a_load = 1'b0; a_en = 1'b1; a_dir = 1'b1;
        step(); chk_a("a.dn1", 2, 1'b0, 1'b0);
        step(); chk_a("a.dn2", 1, 1'b0, 1'b0);
        step(); chk_a("a.dn3", 0, 1'b0, 1'b0);
        step(); chk_a("a.dn4", 15, 1'b1, 1'b0);
        step(); chk_a("a.dn5", 14, 1'b0, 1'b0);

        // Load beats a simultaneous up step.
        a_load = 1'b1; a_ld_idx = 4'd9; a_en = 1'b1; a_dir = 1'b0;
        step(); chk_a("a.loadwin", 9, 1'b0, 1'b0);

        // Loads landing on the ring ends never flag a wrap.
        a_ld_idx = 4'd15;
        step(); chk_a("a.load15", 15, 1'b0, 1'b0);
        a_ld_idx = 4'd0;
        step(); chk_a("a.load0", 0, 1'b0, 1'b0);

        // Direction follows the value sampled at each edge.
        a_load = 1'b0; a_en = 1'b1; a_dir = 1'b1;
        step(); chk_a("a.dirdn", 15, 1'b1, 1'b0);
        a_dir = 1'b0;
        step(); chk_a("a.dirup", 0, 1'b1, 1'b0);
        step(); chk_a("a.dirup2", 1, 1'b0, 1'b0);

        // Hold with EN low.
        a_en = 1'b0; a_dir = 1'b1;
        step(); chk_a("a.hold1", 1, 1'b0, 1'b0);
        step(); chk_a("a.hold2", 1, 1'b0, 1'b0);

        // Mid-run reset from index 7, then resume from 0.
        a_load = 1'b1; a_ld_idx = 4'd7;
        step(); chk_a("a.load7", 7, 1'b0, 1'b0);
        a_load = 1'b1; a_ld_idx = 4'd5; a_en = 1'b1; a_dir = 1'b0; a_rst_n = 1'b0;
        step(); chk_a("a.midrst", 0, 1'b0, 1'b0);
        a_rst_n = 1'b1; a_load = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_a("a.resume", k, 1'b0, 1'b0);
        end
        a_en = 1'b0;

        // Ten-stage ring: reset, step to 4, then an out-of-range load.
        step();
        chk_b("b.reset", 0, 1'b0, 1'b0);
        b_live = 1'b1;
        b_rst_n = 1'b1; b_en = 1'b1; b_dir = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_b("b.up", k, 1'b0, 1'b0);
        end
        b_load = 1'b1; b_ld_idx = 4'd12;
        step(); chk_b("b.badload", 4, 1'b0, 1'b1);
        b_load = 1'b0;
        step(); chk_b("b.resume", 5, 1'b0, 1'b0);
        for (int k = 6; k <= 9; k++) begin
            step();
            chk_b("b.up2", k, 1'b0, 1'b0);
        end
        step(); chk_b("b.wrap", 0, 1'b1, 1'b0);
        b_dir = 1'b1;
        step(); chk_b("b.wrapdn", 9, 1'b1, 1'b0);
        b_load = 1'b1; b_ld_idx = 4'd9; b_en = 1'b0;
        step(); chk_b("b.loadlast", 9, 1'b0, 1'b0);
        b_load = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
